// File: rtl/score_display.sv
// Score display: double-dabble binary-to-BCD converter feeding a multiplexed
// 8-digit common-anode seven-segment display. Optional blink-on-freeze: SCORE_BLINK_EN.
module score_display #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] score_in,
   input  logic        score_valid,
   input  logic        gameover,
   output logic        busy,
   output logic [19:0] bcd_out,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [35:0]       sr_q, sr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [19:0]       bcd_q, bcd_d;
   logic              pend_q, pend_d;
   logic [15:0]       pend_val_q, pend_val_d;
   logic              frozen_q, frozen_d;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]        digit_q, digit_d;
   logic [7:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              accept;
   logic [35:0]       adj;
   logic              blink_off;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'd0:    seg_decode = 7'h40;
         4'd1:    seg_decode = 7'h79;
         4'd2:    seg_decode = 7'h24;
         4'd3:    seg_decode = 7'h30;
         4'd4:    seg_decode = 7'h19;
         4'd5:    seg_decode = 7'h12;
         4'd6:    seg_decode = 7'h02;
         4'd7:    seg_decode = 7'h78;
         4'd8:    seg_decode = 7'h00;
         4'd9:    seg_decode = 7'h10;
         default: seg_decode = 7'h7F;
      endcase
   endfunction

   assign accept = score_valid && !frozen_q;

   // Converter: strobe beats the pending slot; strobes while busy overwrite the slot.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      bcd_d      = bcd_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      frozen_d   = frozen_q | gameover;
      adj        = sr_q;
      for (int i = 0; i < 5; i++) begin
         if (adj[16+4*i +: 4] >= 4'd5) adj[16+4*i +: 4] = adj[16+4*i +: 4] + 4'd3;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               sr_d    = {20'b0, score_in};
               cnt_d   = 4'd0;
               state_d = SHIFT;
            end else if (pend_q) begin
               sr_d    = {20'b0, pend_val_q};
               cnt_d   = 4'd0;
               pend_d  = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sr_d  = {adj[34:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) state_d = DONE;
         end
         DONE: begin
            bcd_d   = sr_q[35:16];
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && accept) begin
         pend_d     = 1'b1;
         pend_val_d = score_in;
      end
   end

`ifdef SCORE_BLINK_EN
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_off_q, blink_off_d;

   always_comb begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
      if (frozen_q) begin
         blink_off_d = blink_off_q;
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_off_d = !blink_off_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_off_q <= blink_off_d;
      end
   end

   assign blink_off = blink_off_q;
`else
   assign blink_off = 1'b0;
`endif

   // Scan and decode; outputs lag digit_q/bcd_q by one register stage.
   always_comb begin
      logic [4:0] upper_zero;
      scan_cnt_d = scan_cnt_q + 1'b1;
      digit_d    = digit_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         digit_d    = (digit_q == 3'd4) ? 3'd0 : digit_q + 3'd1;
      end
      upper_zero[4] = (bcd_q[19:16] == 4'd0);
      for (int i = 3; i >= 0; i--) begin
         upper_zero[i] = upper_zero[i+1] && (bcd_q[4*i +: 4] == 4'd0);
      end
      an_d  = ~(8'h01 << digit_q);
      seg_d = seg_decode(bcd_q[{digit_q, 2'b00} +: 4]);
      if ((digit_q != 3'd0 && upper_zero[digit_q]) || blink_off) seg_d = 7'h7F;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         bcd_q      <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         frozen_q   <= 1'b0;
         scan_cnt_q <= '0;
         digit_q    <= '0;
         an_q       <= 8'hFE;
         seg_q      <= 7'h40;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         bcd_q      <= bcd_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         frozen_q   <= frozen_d;
         scan_cnt_q <= scan_cnt_d;
         digit_q    <= digit_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign bcd_out = bcd_q;
   assign an      = an_q;
   assign seg     = seg_q;
   assign dp      = 1'b1;

endmodule

// File: doc/score_display.md
# score_display

Consumer of the 16-bit game score. Accepts score samples on a strobe, converts each to five BCD digits with an iterative shift-add-3 (double-dabble) engine, and drives an 8-digit, common-anode seven-segment display through time-multiplexed anodes with leading-zero blanking. A `gameover` input freezes the display on the final score. Sits between the score counter and the board display pins.

## Interface
- `SCAN_DIV`, 100000: clocks per digit slot in the anode scan; must be at least 2.
- `BLINK_DIV`, 50000000: clocks per blink half-period. Used only when `SCORE_BLINK_EN` is defined.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high.
- `score_in` in 16: unsigned binary score.
- `score_valid` in 1: one-cycle load strobe for `score_in`.
- `gameover` in 1: level input. Sets the sticky freeze.
- `busy` out 1: conversion in progress.
- `bcd_out` out 20: last converted value, 5 BCD nibbles, digit 4 in [19:16].
- `an` out 8: anode enables, active-low.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low. Held at 1 (off).

## Operation
- **Converter FSM states:** IDLE, SHIFT, DONE. `busy = (state != IDLE)`.
- **Start:** In IDLE, a start occurs if an accepted strobe is present or `pending` is set.
  - Source value: the strobe's `score_in` takes priority over the pending value.
  - Loads a 36-bit shift register {20'b0, value}, clears the iteration count, moves to SHIFT, and clears `pending` if it was consumed.
- **SHIFT:** 16 cycles. Each cycle, add 3 to every BCD nibble ≥ 5, then shift left by 1. After the 16th cycle, move to DONE.
- **DONE:** 1 cycle. Writes the upper 20 bits to `bcd_out`, then moves to IDLE.
- **Strobe while busy:** `score_in` goes into the pending register and `pending` is set. A newer strobe overwrites the stored value. Single-entry buffer; intermediate values are dropped by design.
- **Acceptance:** A strobe is accepted when `score_valid && !frozen`.
- **Freeze:**
  - `frozen` is set the cycle after `gameover` is first seen high. It clears only on reset.
  - A strobe in the same cycle as the first `gameover` is accepted.
  - An in-flight conversion and any pending value complete normally.
- **Scan:**
  - `scan_cnt` counts 0..`SCAN_DIV`-1.
  - At terminal count, `digit` advances 0→1→2→3→4→0.
  - `an[digit]` = 0, all other bits of `an` = 1. `an[7:5]` are always 1.
- **Leading-zero blanking:**
  - Digit n (n ≥ 1) is blanked (`seg` = 7'h7F) when it and all higher digits are 0.
  - Digit 0 is always shown.
- **Segment decode (0–9):** 40,79,24,30,19,12,02,78,00,10 (hex). Nibbles A–F decode to 7F.
- All display outputs are registered.

## Timing
- **Reset values:** state IDLE, `busy` 0, `bcd_out` 0, `pending` 0, `frozen` 0, `scan_cnt` 0, `digit` 0, `an` 8'hFE, `seg` 7'h40, `dp` 1.
- **Conversion latency:**
  - Strobe accepted at edge k → `busy` = 1 after edge k.
  - `bcd_out` is valid and `busy` = 0 after edge k+17.
- **Pending start:** A pending value starts at the edge after DONE. This gives a 17-cycle conversion with a 1-cycle IDLE gap.
- **Display latency:** `an`/`seg` reflect a new `bcd_out` at the next digit slot, or within 1 cycle if the current digit changed.
- **Reset mid-operation:** Aborts the conversion, clears `pending` and `frozen`, and returns all outputs to reset values at the next edge.

## Configuration
- **`SCORE_BLINK_EN` defined:**
  - While `frozen`, a blink counter toggles `blink_off` every `BLINK_DIV` cycles, starting with `blink_off` = 0 when `frozen` sets.
  - When `blink_off` = 1, `seg` = 7'h7F. `an` keeps scanning.
- **`SCORE_BLINK_EN` undefined:** No blink logic is built. The frozen display is steady.

## Test plan
1. **Reset:** Assert reset for 3 cycles → `an` = FE, `seg` = 40, `dp` = 1, `busy` = 0, `bcd_out` = 0.
2. **Full-scale conversion:** Strobe `score_in` = 16'hFFFF → `busy` high for exactly 17 cycles, then `bcd_out` = 20'h65535. Also check 0 → 20'h00000 and 65500 → 20'h65500.
3. **Pending buffer:** Strobe 1234, then 42 at +3 cycles, then 7 at +5 cycles → `bcd_out` sequence is 01234 then 00007. 42 never appears. Second conversion completes 35 cycles after the first strobe.
4. **Scan and blanking (`SCAN_DIV` = 4):** `bcd_out` = 00107 → `an` steps FE, FD, FB, F7, EF every 4 cycles with `seg` = 78, 40, 79, 7F, 7F.
5. **Freeze:** `gameover` and strobe 500 in the same cycle → `bcd_out` = 00500. Later strobe 600 → ignored, `bcd_out` stays 00500. Reset clears the freeze, and a following strobe of 600 converts.
6. **Blink (`BLINK_DIV` = 8):** With `SCORE_BLINK_EN` defined and frozen → `seg` alternates between the normal value and 7F every 8 cycles. With the macro undefined → no 7F gaps on non-blanked digits.
